vmem_ctrl: RTL and testbench
============================

Name: vmem_ctrl

Overview:
- Parametrised video-memory controller: on-chip frame buffer with pixel-packed words.
- Serves the VGA scan-out read stream through a fixed 2-cycle pipeline that aligns RGB with the delayed display enable.
- Accepts pixel writes from the CPU/draw side through a valid/ready handshake and a small write FIFO; writes drain only while the display enable is low, so no pixel changes under the beam.
- Sits between the VGA timing generator and the RGB pins.

Parameters:
CH_BITS, 4, bits per colour channel; pixel width PIX_BITS = 3*CH_BITS
ADDR_W, 19, pixel address width
NPIX, 327680, frame-buffer size in pixels; must be a multiple of PPW
PPW, 1, pixels packed per memory word; 1, 2 or 4
WFIFO_DEPTH, 4, write FIFO entries; power of 2, at least 2
CLEAR_COLOR, 0, PIX_BITS fill value used by the optional clear

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  asynchronous active-low reset
position  in  ADDR_W  scan-out pixel address
en  in  1  display-active enable, aligned with position
vga_r  out  CH_BITS  red, pipelined
vga_g  out  CH_BITS  green, pipelined
vga_b  out  CH_BITS  blue, pipelined
vga_en  out  1  en delayed by 2 cycles, aligned with RGB
wr_valid  in  1  write request
wr_ready  out  1  FIFO can accept
wr_addr  in  ADDR_W  pixel address to write
wr_data  in  PIX_BITS  pixel value {r,g,b}
busy  out  1  FIFO non-empty, or clear in progress

Behaviour:
- Reset, asynchronous on rst_n low:
  - vga_r/g/b = 0, vga_en = 0, pipeline enables = 0.
  - FIFO empty: pointers = 0, count = 0.
  - wr_ready = 1, busy = 0 (without VMEM_CLEAR_EN).
  - Memory contents are not reset.
- Memory organisation: NPIX/PPW words of PPW*PIX_BITS bits, built as PPW independent lanes.
  - Word index = addr / PPW; lane = addr % PPW; lane 0 is the low-order pixel.
- Read pipeline:
  - Cycle 0: position and en sampled.
  - Cycle 1: synchronous word read; lane index and en registered.
  - Cycle 2: lane selected and split into r = [PIX_BITS-1 -: CH_BITS], g = middle, b = low; registered to outputs together with vga_en.
  - Latency is exactly 2 cycles.
  - When the delayed en = 0, outputs are forced to 0.
  - position >= NPIX while en = 1 outputs 0 (black); no wrap-around.
- Write FIFO:
  - Push when wr_valid && wr_ready.
  - wr_ready = (count < WFIFO_DEPTH).
  - Push while full is ignored; the master must hold its request until ready.
- Drain:
  - One entry per cycle, issued when count > 0 and en = 0 in that cycle.
  - Only the addressed lane is written: per-lane write enable, other lanes untouched.
  - wr_addr >= NPIX: entry is popped and discarded.
- Simultaneous push and pop: count unchanged; a full FIFO that drains in the same cycle still reports wr_ready = 0 that cycle (ready is computed from the registered count).
- Read/write to the same word in the same cycle cannot occur, because drain requires en = 0; while en = 0 read data is masked anyway.
- Pointers wrap modulo WFIFO_DEPTH.
- busy = (count != 0).
- Reset asserted mid-operation: FIFO contents are lost and a drain in flight is aborted (no partial write).

Optional Feature:
- Macro VMEM_CLEAR_EN.
- Defined:
  - After rst_n deasserts, a CLEAR state sweeps word index 0 .. NPIX/PPW-1, one word per cycle, writing CLEAR_COLOR into every lane regardless of en.
  - During the sweep: wr_ready = 0, busy = 1, RGB outputs = 0 even if en = 1.
  - Sweep duration: NPIX/PPW cycles.
  - State machine: CLEAR -> RUN; reset always returns it to CLEAR.
- Not defined: the block starts directly in RUN, memory is uninitialised, and busy reflects the FIFO only.

Test Plan:
- Read alignment, PPW=1: preload addr 5 = 12'hA3C; drive position=5, en=1 at cycle t -> at t+2 vga_r=4'hA, vga_g=4'h3, vga_b=4'hC, vga_en=1; with en=0 all outputs are 0 at t+2.
- Packed lanes, PPW=4: write addr 8 = 12'hF00 and addr 9 = 12'h0F0 while en=0; read 8, 9, 10 -> F00, 0F0, then the prior contents of addr 10, confirming other lanes are unchanged.
- Blank-gated drain: hold en=1 and push 4 writes -> wr_ready=0 after the 4th, busy=1, memory unchanged; drop en -> 4 writes complete in 4 cycles, then busy=0 and wr_ready=1.
- Full with simultaneous push/pop: FIFO full, en=0, wr_valid=1 -> one pop that cycle with wr_ready=0; the push is accepted next cycle; count ends at 4.
- Out-of-range: write addr 327680 -> popped with no memory change; read position 327681 with en=1 -> RGB = 0.
- VMEM_CLEAR_EN, NPIX=64, PPW=2, CLEAR_COLOR=12'h123: release reset -> busy=1 and wr_ready=0 for 32 cycles; every subsequent read returns 12'h123.

Source files
------------

// File: rtl/vmem_if.sv
// rtl/vmem_if.sv - pixel write handshake bundle for vmem_ctrl
interface vmem_if #(
  parameter int ADDR_W   = 19,
  parameter int PIX_BITS = 12
);
  logic                wr_valid;
  logic                wr_ready;
  logic [ADDR_W-1:0]   wr_addr;
  logic [PIX_BITS-1:0] wr_data;
  logic                busy;

  modport master (output wr_valid, wr_addr, wr_data, input wr_ready, busy);
  modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready, busy);
endinterface

// File: rtl/vmem_ctrl.sv
// rtl/vmem_ctrl.sv - frame buffer with 2-cycle scan-out pipeline and blank-gated write FIFO; VMEM_CLEAR_EN adds a post-reset clear sweep
module vmem_ctrl #(
  parameter int                   CH_BITS     = 4,
  parameter int                   ADDR_W      = 19,
  parameter int                   NPIX        = 327680,
  parameter int                   PPW         = 1,
  parameter int                   WFIFO_DEPTH = 4,
  parameter logic [3*CH_BITS-1:0] CLEAR_COLOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  position,
  input  logic               en,
  output logic [CH_BITS-1:0] vga_r,
  output logic [CH_BITS-1:0] vga_g,
  output logic [CH_BITS-1:0] vga_b,
  output logic               vga_en,
  vmem_if.slave              wr
);
  localparam int PIX_BITS = 3 * CH_BITS;
  localparam int NWORDS   = NPIX / PPW;
  localparam int WORD_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LANE_W   = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int SHIFT    = $clog2(PPW);
  localparam int PTR_W    = $clog2(WFIFO_DEPTH);
  localparam logic [ADDR_W:0] NPIX_L  = (ADDR_W+1)'(NPIX);
  localparam logic [PTR_W:0]  DEPTH_L = (PTR_W+1)'(WFIFO_DEPTH);

  function automatic logic [WORD_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return WORD_W'(a >> SHIFT);
  endfunction

  function automatic logic [LANE_W-1:0] lane_of(input logic [ADDR_W-1:0] a);
    return (PPW > 1) ? a[LANE_W-1:0] : '0;
  endfunction

  logic              clearing;
  logic [WORD_W-1:0] clr_idx;

`ifdef VMEM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t state;

  // Sweep every word once after reset, then hand over to normal operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
    end else if (state == S_CLEAR) begin
      if (clr_idx == WORD_W'(NWORDS - 1)) state <= S_RUN;
      clr_idx <= clr_idx + 1'b1;
    end
  end
  assign clearing = (state == S_CLEAR);
`else
  assign clearing = 1'b0;
  assign clr_idx  = '0;
`endif

  // Write FIFO
  logic [ADDR_W-1:0]   f_addr [WFIFO_DEPTH];
  logic [PIX_BITS-1:0] f_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]    wptr, rptr;
  logic [PTR_W:0]      count;
  logic                push, pop;

  assign wr.wr_ready = (count < DEPTH_L) && !clearing;
  assign wr.busy     = (count != '0) || clearing;
  assign push        = wr.wr_valid && wr.wr_ready;
  assign pop         = (count != '0) && !en && !clearing;

  // FIFO storage needs no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wptr] <= wr.wr_addr;
      f_data[wptr] <= wr.wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Memory write port: either the clear sweep or the FIFO head
  logic [ADDR_W-1:0]   h_addr;
  logic                h_ok;
  logic [WORD_W-1:0]   mw_word;
  logic [LANE_W-1:0]   mw_lane;
  logic [PIX_BITS-1:0] mw_data;
  logic                mw_any;

  assign h_addr  = f_addr[rptr];
  assign h_ok    = ({1'b0, h_addr} < NPIX_L);
  assign mw_word = clearing ? clr_idx : word_of(h_addr);
  assign mw_lane = lane_of(h_addr);
  assign mw_data = clearing ? CLEAR_COLOR : f_data[rptr];
  assign mw_any  = rst_n && (clearing || (pop && h_ok));

  // Read address: out-of-range positions read word 0 and are masked later
  logic                    rd_ok;
  logic [WORD_W-1:0]       rd_word;
  logic [PPW*PIX_BITS-1:0] rd_bus;

  assign rd_ok   = ({1'b0, position} < NPIX_L);
  assign rd_word = rd_ok ? word_of(position) : '0;

  for (genvar l = 0; l < PPW; l++) begin : g_lane
    logic [PIX_BITS-1:0] ram [NWORDS];
    logic [PIX_BITS-1:0] q;

    // One lane of the frame buffer: private write enable, shared read address
    always_ff @(posedge clk) begin
      if (mw_any && (clearing || mw_lane == LANE_W'(l))) ram[mw_word] <= mw_data;
      q <= ram[rd_word];
    end
    assign rd_bus[l*PIX_BITS +: PIX_BITS] = q;
  end

  // Stage 1: carry enable, range/clear mask and lane alongside the RAM read
  logic              en_q, ok_q;
  logic [LANE_W-1:0] lane_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      ok_q   <= 1'b0;
      lane_q <= '0;
    end else begin
      en_q   <= en;
      ok_q   <= en && rd_ok && !clearing;
      lane_q <= lane_of(position);
    end
  end

  logic [PIX_BITS-1:0] pix;
  assign pix = rd_bus[lane_q*PIX_BITS +: PIX_BITS];

  // Stage 2: select lane, split channels, black whenever the pixel is not displayable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_en                <= 1'b0;
    end else begin
      vga_en <= en_q;
      if (ok_q) {vga_r, vga_g, vga_b} <= pix;
      else      {vga_r, vga_g, vga_b} <= '0;
    end
  end
endmodule

// File: tb/tb_vmem_ctrl.sv
// tb/tb_vmem_ctrl.sv - directed self-checking bench for vmem_ctrl
module tb_vmem_ctrl;
`ifdef VMEM_CLEAR_EN
  localparam int NPIX1 = 1024;
`else
  localparam int NPIX1 = 327680;
`endif

  logic        clk, rst_n;
  logic [18:0] pos1, pos4;
  logic        en1, en4;
  logic [3:0]  r1, g1, b1, r4, g4, b4;
  logic        ve1, ve4;
  int          n_tests = 0;
  int          n_fail  = 0;

  vmem_if #(.ADDR_W(19), .PIX_BITS(12)) w1();
  vmem_if #(.ADDR_W(19), .PIX_BITS(12)) w4();

  vmem_ctrl #(.NPIX(NPIX1), .PPW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .position(pos1), .en(en1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_en(ve1), .wr(w1));

  vmem_ctrl #(.NPIX(64), .PPW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .position(pos4), .en(en4),
    .vga_r(r4), .vga_g(g4), .vga_b(b4), .vga_en(ve4), .wr(w4));

`ifdef VMEM_CLEAR_EN
  logic [18:0] posc;
  logic        enc;
  logic [3:0]  rc, gc, bc;
  logic        vec;
  vmem_if #(.ADDR_W(19), .PIX_BITS(12)) wc();
  vmem_ctrl #(.NPIX(64), .PPW(2), .CLEAR_COLOR(12'h123)) dutc (
    .clk(clk), .rst_n(rst_n), .position(posc), .en(enc),
    .vga_r(rc), .vga_g(gc), .vga_b(bc), .vga_en(vec), .wr(wc));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required finish before 900000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [18:0] a, input logic [11:0] d);
    int n = 0;
    w1.wr_valid = 1'b1; w1.wr_addr = a; w1.wr_data = d;
    while (w1.wr_ready !== 1'b1 && n < 50) begin tick(); n++; end
    n_tests++;
    if (n >= 50) begin n_fail++; $display("FAIL push1_timeout ready=%b required 1", w1.wr_ready); end
    tick();
    w1.wr_valid = 1'b0;
  endtask

  task automatic push4(input logic [18:0] a, input logic [11:0] d);
    int n = 0;
    w4.wr_valid = 1'b1; w4.wr_addr = a; w4.wr_data = d;
    while (w4.wr_ready !== 1'b1 && n < 50) begin tick(); n++; end
    n_tests++;
    if (n >= 50) begin n_fail++; $display("FAIL push4_timeout ready=%b required 1", w4.wr_ready); end
    tick();
    w4.wr_valid = 1'b0;
  endtask

  task automatic idle1();
    int n = 0;
    while (w1.busy !== 1'b0 && n < 3000) begin tick(); n++; end
    n_tests++;
    if (n >= 3000) begin n_fail++; $display("FAIL idle1_timeout busy=%b required 0", w1.busy); end
  endtask

  task automatic idle4();
    int n = 0;
    while (w4.busy !== 1'b0 && n < 3000) begin tick(); n++; end
    n_tests++;
    if (n >= 3000) begin n_fail++; $display("FAIL idle4_timeout busy=%b required 0", w4.busy); end
  endtask

  task automatic test_reset();
    logic exp_rdy, exp_busy;
`ifdef VMEM_CLEAR_EN
    exp_rdy = 1'b0; exp_busy = 1'b1;
`else
    exp_rdy = 1'b1; exp_busy = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({r1, g1, b1} !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got=%h required 000", {r1, g1, b1}); end
    n_tests++;
    if (ve1 !== 1'b0) begin n_fail++; $display("FAIL reset_vga_en got=%b required 0", ve1); end
    n_tests++;
    if (w1.wr_ready !== exp_rdy) begin n_fail++; $display("FAIL reset_ready got=%b required %b", w1.wr_ready, exp_rdy); end
    n_tests++;
    if (w1.busy !== exp_busy) begin n_fail++; $display("FAIL reset_busy got=%b required %b", w1.busy, exp_busy); end
    rst_n = 1'b1;
    idle1();
    idle4();
  endtask

  task automatic test_read_align();
    en1 = 1'b0;
    push1(19'd5, 12'hA3C);
    idle1();
    pos1 = 19'd5; en1 = 1'b1;
    tick();
    n_tests++;
    if (ve1 !== 1'b0) begin n_fail++; $display("FAIL align_early_en got=%b required 0", ve1); end
    tick();
    n_tests++;
    if ({r1, g1, b1} !== 12'hA3C) begin n_fail++; $display("FAIL align_rgb got=%h required a3c", {r1, g1, b1}); end
    n_tests++;
    if (ve1 !== 1'b1) begin n_fail++; $display("FAIL align_en got=%b required 1", ve1); end
    en1 = 1'b0;
    tick(); tick();
    n_tests++;
    if ({r1, g1, b1, ve1} !== 13'h0) begin n_fail++; $display("FAIL align_blank got=%h required 0000", {r1, g1, b1, ve1}); end
  endtask

  task automatic test_packed_lanes();
    logic [18:0] ra [4];
    logic [11:0] rd [4];
    ra = '{19'd8, 19'd9, 19'd10, 19'd11};
    rd = '{12'hF00, 12'h0F0, 12'h555, 12'hAAA};
    en4 = 1'b0;
    push4(19'd10, 12'h555);
    push4(19'd11, 12'hAAA);
    push4(19'd8, 12'hF00);
    push4(19'd9, 12'h0F0);
    idle4();
    en4 = 1'b1; pos4 = ra[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      pos4 = (i < 3) ? ra[i+1] : ra[i];
      tick();
      n_tests++;
      if ({r4, g4, b4} !== rd[i]) begin n_fail++; $display("FAIL packed_lane addr=%0d got=%h required %h", ra[i], {r4, g4, b4}, rd[i]); end
    end
    en4 = 1'b0;
  endtask

  task automatic test_blank_gate();
    logic [11:0] rd [4];
    rd = '{12'h111, 12'h222, 12'h333, 12'h444};
    en1 = 1'b0;
    push1(19'd20, 12'h0F0);
    idle1();
    en1 = 1'b1; pos1 = 19'd20;
    for (int i = 0; i < 4; i++) push1(19'(20 + i), rd[i]);
    n_tests++;
    if (w1.wr_ready !== 1'b0) begin n_fail++; $display("FAIL gate_full_ready got=%b required 0", w1.wr_ready); end
    n_tests++;
    if (w1.busy !== 1'b1) begin n_fail++; $display("FAIL gate_busy got=%b required 1", w1.busy); end
    n_tests++;
    if ({r1, g1, b1} !== 12'h0F0) begin n_fail++; $display("FAIL gate_mem_unchanged got=%h required 0f0", {r1, g1, b1}); end
    en1 = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (w1.busy !== 1'b1) begin n_fail++; $display("FAIL gate_drain3_busy got=%b required 1", w1.busy); end
    tick();
    n_tests++;
    if ({w1.busy, w1.wr_ready} !== 2'b01) begin n_fail++; $display("FAIL gate_drain4 busy,ready got=%b required 01", {w1.busy, w1.wr_ready}); end
    en1 = 1'b1; pos1 = 19'd20;
    tick();
    for (int i = 0; i < 4; i++) begin
      pos1 = 19'(21 + i);
      tick();
      n_tests++;
      if ({r1, g1, b1} !== rd[i]) begin n_fail++; $display("FAIL gate_readback addr=%0d got=%h required %h", 20 + i, {r1, g1, b1}, rd[i]); end
    end
    en1 = 1'b0;
  endtask

  task automatic test_full_simul();
    logic [11:0] rd [5];
    rd = '{12'hA01, 12'hA02, 12'hA03, 12'hA04, 12'hB05};
    en1 = 1'b1;
    for (int i = 0; i < 4; i++) push1(19'(30 + i), rd[i]);
    w1.wr_valid = 1'b1; w1.wr_addr = 19'd34; w1.wr_data = 12'hB05; en1 = 1'b0;
    n_tests++;
    if (w1.wr_ready !== 1'b0) begin n_fail++; $display("FAIL simul_ready_full got=%b required 0", w1.wr_ready); end
    tick();
    en1 = 1'b1;
    n_tests++;
    if (w1.wr_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready_after_pop got=%b required 1", w1.wr_ready); end
    tick();
    w1.wr_valid = 1'b0;
    n_tests++;
    if ({w1.busy, w1.wr_ready} !== 2'b10) begin n_fail++; $display("FAIL simul_refull busy,ready got=%b required 10", {w1.busy, w1.wr_ready}); end
    en1 = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (w1.busy !== 1'b1) begin n_fail++; $display("FAIL simul_count4 busy got=%b required 1", w1.busy); end
    tick();
    n_tests++;
    if (w1.busy !== 1'b0) begin n_fail++; $display("FAIL simul_empty busy got=%b required 0", w1.busy); end
    en1 = 1'b1; pos1 = 19'd30;
    tick();
    for (int i = 0; i < 5; i++) begin
      pos1 = 19'(31 + i);
      tick();
      n_tests++;
      if ({r1, g1, b1} !== rd[i]) begin n_fail++; $display("FAIL simul_readback addr=%0d got=%h required %h", 30 + i, {r1, g1, b1}, rd[i]); end
    end
    en1 = 1'b0;
  endtask

  task automatic test_out_of_range();
    en1 = 1'b0;
    push1(19'd0, 12'h5A5);
    idle1();
    push1(19'(NPIX1), 12'hFFF);
    n_tests++;
    if (w1.busy !== 1'b1) begin n_fail++; $display("FAIL oor_queued busy got=%b required 1", w1.busy); end
    tick();
    n_tests++;
    if (w1.busy !== 1'b0) begin n_fail++; $display("FAIL oor_popped busy got=%b required 0", w1.busy); end
    en1 = 1'b1; pos1 = 19'd0;
    tick(); tick();
    n_tests++;
    if ({r1, g1, b1} !== 12'h5A5) begin n_fail++; $display("FAIL oor_mem_unchanged got=%h required 5a5", {r1, g1, b1}); end
    pos1 = 19'(NPIX1 + 1);
    tick(); tick();
    n_tests++;
    if ({r1, g1, b1, ve1} !== 13'h1) begin n_fail++; $display("FAIL oor_read rgb,en got=%h required 0001", {r1, g1, b1, ve1}); end
    en1 = 1'b0;
  endtask

`ifdef VMEM_CLEAR_EN
  task automatic test_clear();
    enc = 1'b0; posc = '0;
    wc.wr_valid = 1'b0; wc.wr_addr = '0; wc.wr_data = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      n_tests++;
      if ({wc.busy, wc.wr_ready} !== 2'b10) begin n_fail++; $display("FAIL clear_sweep cycle=%0d busy,ready got=%b required 10", k, {wc.busy, wc.wr_ready}); end
      tick();
    end
    n_tests++;
    if ({wc.busy, wc.wr_ready} !== 2'b01) begin n_fail++; $display("FAIL clear_done busy,ready got=%b required 01", {wc.busy, wc.wr_ready}); end
    enc = 1'b1; posc = '0;
    tick();
    for (int i = 0; i < 64; i++) begin
      posc = 19'(i + 1);
      tick();
      n_tests++;
      if ({rc, gc, bc} !== 12'h123) begin n_fail++; $display("FAIL clear_read addr=%0d got=%h required 123", i, {rc, gc, bc}); end
    end
    enc = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    pos1 = '0; en1 = 1'b0; pos4 = '0; en4 = 1'b0;
    w1.wr_valid = 1'b0; w1.wr_addr = '0; w1.wr_data = '0;
    w4.wr_valid = 1'b0; w4.wr_addr = '0; w4.wr_data = '0;
`ifdef VMEM_CLEAR_EN
    enc = 1'b0; posc = '0;
    wc.wr_valid = 1'b0; wc.wr_addr = '0; wc.wr_data = '0;
`endif
    test_reset();
    test_read_align();
    test_packed_lanes();
    test_blank_gate();
    test_full_simul();
    test_out_of_range();
`ifdef VMEM_CLEAR_EN
    test_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
